// File: rtl/fft_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_seq_pkg
//  Description : Shared state encoding and default sizes for the FFT frame
//                sequencer and its peak tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_seq_pkg;

    localparam int FRAME_LEN_DEF = 512;
    localparam int MAG_W_DEF     = 34;
    localparam int IDX_W         = $clog2(FRAME_LEN_DEF);

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_FILL  = 3'd1,
        ST_START = 3'd2,
        ST_FEED  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_frame_sequencer_peak_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : peak_tracker
//  Description : Clocked running-maximum over pairs of squared-magnitude bins;
//                ties resolve to the earliest (lowest-index) bin.
//  Revision    : 1.0 - initial release
// ============================================================================
module peak_tracker
    import fft_seq_pkg::*;
#(
    parameter int MAG_W     = MAG_W_DEF,
    parameter int BIN_IDX_W = IDX_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 first,
    input  logic [MAG_W-1:0]     mag0,
    input  logic [MAG_W-1:0]     mag1,
    input  logic [BIN_IDX_W-1:0] idx,
    output logic [MAG_W-1:0]     max_mag,
    output logic [BIN_IDX_W:0]   max_bin
);

    logic                 w_odd_wins;
    logic [MAG_W-1:0]     w_cand_mag;
    logic [BIN_IDX_W:0]   w_cand_bin;
    logic [MAG_W-1:0]     r_max_mag;
    logic [BIN_IDX_W:0]   r_max_bin;

    // Strict compares: equal pairs favour the even bin, equal frames the earlier bin.
    assign w_odd_wins = (mag1 > mag0);
    assign w_cand_mag = w_odd_wins ? mag1 : mag0;
    assign w_cand_bin = {idx, w_odd_wins};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_max_mag <= '0;
            r_max_bin <= '0;
        end else if (en && (first || (w_cand_mag > r_max_mag))) begin
            r_max_mag <= w_cand_mag;
            r_max_bin <= w_cand_bin;
        end
    end

    assign max_mag = r_max_mag;
    assign max_bin = r_max_bin;

endmodule
`default_nettype wire

// File: rtl/fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fft_frame_sequencer
//  Description : Frame controller between the ping-pong sample FIFOs and the
//                streaming DFT core; reports the strongest output bin per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int FRAME_LEN   = FRAME_LEN_DEF,
    parameter int MAG_W       = MAG_W_DEF,
    parameter int OUT_TIMEOUT = 4096
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         full_even,
    input  logic                         full_odd,
    input  logic                         fft_next_out,
    input  logic [MAG_W-1:0]             mag0,
    input  logic [MAG_W-1:0]             mag1,
    output logic                         write_even,
    output logic                         write_odd,
    output logic                         read,
    output logic                         fft_reset,
    output logic                         fft_next,
    output logic [$clog2(FRAME_LEN)-1:0] out_index,
    output logic [$clog2(FRAME_LEN):0]   peak_bin,
    output logic [MAG_W-1:0]             peak_mag,
    output logic                         peak_valid,
    output logic                         timeout_err,
    output logic                         busy
);

    localparam int c_IDX_W   = $clog2(FRAME_LEN);
    localparam int c_CNT_MAX = (FRAME_LEN > OUT_TIMEOUT) ? FRAME_LEN : OUT_TIMEOUT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX);
    localparam logic [c_CNT_W-1:0] c_LAST_SAMPLE = c_CNT_W'(FRAME_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_WAIT   = c_CNT_W'(OUT_TIMEOUT - 1);

    seq_state_t          r_state;
    seq_state_t          w_state_next;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_next;
    logic                w_timeout_set;
    logic                r_write_even;
    logic                r_write_odd;
    logic                r_timeout_err;
    logic [c_IDX_W:0]    r_peak_bin;
    logic [MAG_W-1:0]    r_peak_mag;
    logic [c_IDX_W:0]    w_max_bin;
    logic [MAG_W-1:0]    w_max_mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // One counter serves both the feed/drain sample index and the WAIT timeout.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_timeout_set = 1'b0;
        case (r_state)
            ST_CLEAR: w_state_next = ST_FILL;
            ST_FILL: begin
                if (full_even && full_odd) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_state_next = ST_FEED;
                w_cnt_next   = '0;
            end
            ST_FEED: begin
                if (r_cnt == c_LAST_SAMPLE) begin
                    w_state_next = ST_WAIT;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (fft_next_out) begin
                    w_state_next = ST_DRAIN;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_LAST_WAIT) begin
                    w_state_next  = ST_CLEAR;
                    w_cnt_next    = '0;
                    w_timeout_set = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (r_cnt == c_LAST_SAMPLE) begin
                    w_state_next = ST_DONE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_W'(1);
                end
            end
            ST_DONE:  w_state_next = ST_FILL;
            default:  w_state_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= '0;
            r_write_even  <= 1'b0;
            r_write_odd   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_peak_bin    <= '0;
            r_peak_mag    <= '0;
        end else begin
            r_cnt        <= w_cnt_next;
            r_write_even <= (w_state_next == ST_FILL) && !full_even;
            r_write_odd  <= (w_state_next == ST_FILL) && !full_odd;
            if (w_timeout_set) begin
                r_timeout_err <= 1'b1;
            end
            if (r_state == ST_DONE) begin
                r_peak_bin <= w_max_bin;
                r_peak_mag <= w_max_mag;
            end
        end
    end

    peak_tracker #(
        .MAG_W     (MAG_W),
        .BIN_IDX_W (c_IDX_W)
    ) u_peak_tracker (
        .clk     (clk),
        .reset   (reset),
        .en      (r_state == ST_DRAIN),
        .first   (r_cnt == '0),
        .mag0    (mag0),
        .mag1    (mag1),
        .idx     (r_cnt[c_IDX_W-1:0]),
        .max_mag (w_max_mag),
        .max_bin (w_max_bin)
    );

    assign write_even  = r_write_even;
    assign write_odd   = r_write_odd;
    assign read        = (r_state == ST_FEED);
    assign fft_reset   = (r_state == ST_CLEAR);
    assign fft_next    = (r_state == ST_START);
    assign busy        = (r_state != ST_FILL);
    assign peak_valid  = (r_state == ST_DONE);
    assign timeout_err = r_timeout_err;
    assign out_index   = (r_state == ST_DRAIN) ? r_cnt[c_IDX_W-1:0] : '0;
    // During DONE the tracker already holds the final result; the copy holds it afterwards.
    assign peak_bin    = (r_state == ST_DONE) ? w_max_bin : r_peak_bin;
    assign peak_mag    = (r_state == ST_DONE) ? w_max_mag : r_peak_mag;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_frame_sequencer
//  Description : Directed self-checking bench for fft_frame_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_frame_sequencer;

    localparam int c_FRAME_LEN   = 8;
    localparam int c_MAG_W       = 34;
    localparam int c_OUT_TIMEOUT = 32;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               full_even = 1'b0;
    logic               full_odd = 1'b0;
    logic               fft_next_out = 1'b0;
    logic [c_MAG_W-1:0] mag0 = '0;
    logic [c_MAG_W-1:0] mag1 = '0;
    logic               write_even, write_odd, read, fft_reset, fft_next;
    logic [2:0]         out_index;
    logic [3:0]         peak_bin;
    logic [c_MAG_W-1:0] peak_mag;
    logic               peak_valid, timeout_err, busy;

    logic [c_MAG_W-1:0] r_m0 [c_FRAME_LEN];
    logic [c_MAG_W-1:0] r_m1 [c_FRAME_LEN];

    int n_assert = 0;
    int n_fail   = 0;

    fft_frame_sequencer #(
        .FRAME_LEN   (c_FRAME_LEN),
        .MAG_W       (c_MAG_W),
        .OUT_TIMEOUT (c_OUT_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .full_even    (full_even),
        .full_odd     (full_odd),
        .fft_next_out (fft_next_out),
        .mag0         (mag0),
        .mag1         (mag1),
        .write_even   (write_even),
        .write_odd    (write_odd),
        .read         (read),
        .fft_reset    (fft_reset),
        .fft_next     (fft_next),
        .out_index    (out_index),
        .peak_bin     (peak_bin),
        .peak_mag     (peak_mag),
        .peak_valid   (peak_valid),
        .timeout_err  (timeout_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // From a FILL cycle: raise both full flags and stop on the fft_next cycle.
    task automatic fill_fast();
        int t;
        t = 0;
        full_even = 1'b1;
        full_odd  = 1'b1;
        do begin
            next_cycle();
            t++;
        end while (fft_next !== 1'b1 && t < 20);
        chk("fft_next_seen", fft_next, 1);
    endtask

    // From the fft_next cycle: count reads, release the DFT output, drain r_m0/r_m1.
    task automatic feed_drain(input logic [3:0] exp_bin, input logic [c_MAG_W-1:0] exp_mag,
                              input logic [3:0] prev_bin, input logic [c_MAG_W-1:0] prev_mag);
        int reads;
        reads = 0;
        full_even = 1'b0;
        full_odd  = 1'b0;
        chk("hold_bin_at_start", peak_bin, prev_bin);
        for (int i = 0; i < c_FRAME_LEN + 2; i++) begin
            next_cycle();
            if (i == 0) chk("first_read", read, 1);
            if (read === 1'b1) reads++;
        end
        chk("read_count", reads, c_FRAME_LEN);
        fft_next_out = 1'b1;
        next_cycle();
        fft_next_out = 1'b0;
        for (int k = 0; k < c_FRAME_LEN; k++) begin
            mag0 = r_m0[k];
            mag1 = r_m1[k];
            chk("out_index", out_index, k);
            if (k == c_FRAME_LEN - 1) begin
                chk("no_early_valid", peak_valid, 0);
                chk("hold_bin_drain", peak_bin, prev_bin);
                chk("hold_mag_drain", peak_mag, prev_mag);
            end
            next_cycle();
        end
        mag0 = '0;
        mag1 = '0;
        chk("done_valid", peak_valid, 1);
        chk("done_bin", peak_bin, exp_bin);
        chk("done_mag", peak_mag, exp_mag);
        next_cycle();
        chk("valid_one_cycle", peak_valid, 0);
        chk("fill_not_busy", busy, 0);
        chk("held_bin", peak_bin, exp_bin);
        chk("held_mag", peak_mag, exp_mag);
    endtask

    initial begin
        int pv;
        repeat (3) next_cycle();
        chk("rst_busy", busy, 1);
        chk("rst_write_even", write_even, 0);
        chk("rst_write_odd", write_odd, 0);
        chk("rst_read", read, 0);
        chk("rst_fft_next", fft_next, 0);
        chk("rst_peak_valid", peak_valid, 0);
        chk("rst_peak_bin", peak_bin, 0);
        chk("rst_peak_mag", peak_mag, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_out_index", out_index, 0);
        reset = 1'b0;                 // cycle 0: CLEAR
        next_cycle();                 // cycle 1: FILL
        chk("fill_busy", busy, 0);
        chk("fill_we", write_even, 1);
        chk("fill_wo", write_odd, 1);
        repeat (9) next_cycle();      // cycle 10
        full_even = 1'b1;
        chk("we_c10", write_even, 1);
        next_cycle();                 // cycle 11
        chk("we_c11", write_even, 0);
        chk("wo_c11", write_odd, 1);
        repeat (3) next_cycle();      // cycle 14
        full_odd = 1'b1;
        chk("fft_next_c14", fft_next, 0);
        chk("wo_c14", write_odd, 1);
        next_cycle();                 // cycle 15
        chk("fft_next_c15", fft_next, 1);
        chk("wo_c15", write_odd, 0);
        chk("read_c15", read, 0);

        r_m0 = '{34'd5, 34'd9, 34'd2,  34'd1, 34'd0, 34'd3, 34'd4, 34'd6};
        r_m1 = '{34'd1, 34'd9, 34'd30, 34'd2, 34'd8, 34'd7, 34'd0, 34'd5};
        feed_drain(4'd5, 34'd30, 4'd0, 34'd0);

        r_m0 = '{34'd7, 34'd7, 34'd7, 34'd7, 34'd7, 34'd7, 34'd7, 34'd7};
        r_m1 = '{34'd7, 34'd7, 34'd7, 34'd7, 34'd7, 34'd7, 34'd7, 34'd7};
        fill_fast();
        feed_drain(4'd0, 34'd7, 4'd5, 34'd30);

        r_m0 = '{34'd1, 34'd2, 34'd3, 34'd4,  34'd5, 34'd6, 34'd100, 34'd7};
        r_m1 = '{34'd0, 34'd0, 34'd0, 34'd50, 34'd0, 34'd0, 34'd0,   34'd0};
        fill_fast();
        feed_drain(4'd12, 34'd100, 4'd0, 34'd7);

        // Timeout: fft_next_out never arrives.
        fill_fast();
        full_even = 1'b0;
        full_odd  = 1'b0;
        pv = 0;
        for (int i = 1; i <= c_FRAME_LEN + c_OUT_TIMEOUT; i++) begin
            next_cycle();
            if (peak_valid === 1'b1) pv++;
            if (i == c_FRAME_LEN + c_OUT_TIMEOUT) chk("timeout_not_yet", timeout_err, 0);
        end
        next_cycle();
        if (peak_valid === 1'b1) pv++;
        chk("timeout_set", timeout_err, 1);
        chk("timeout_fft_reset", fft_reset, 1);
        chk("timeout_busy", busy, 1);
        chk("timeout_no_valid", pv, 0);
        next_cycle();
        chk("after_clear_fft_reset", fft_reset, 0);
        chk("timeout_sticky", timeout_err, 1);
        chk("after_clear_fill", busy, 0);
        chk("timeout_peak_held", peak_bin, 12);

        // Reset during FEED at cnt=3.
        fill_fast();
        full_even = 1'b0;
        full_odd  = 1'b0;
        repeat (4) next_cycle();
        chk("feed_cnt3_read", read, 1);
        reset = 1'b1;
        next_cycle();
        chk("midrst_read", read, 0);
        chk("midrst_busy", busy, 1);
        chk("midrst_peak_bin", peak_bin, 0);
        chk("midrst_peak_mag", peak_mag, 0);
        chk("midrst_valid", peak_valid, 0);
        chk("midrst_timeout_clr", timeout_err, 0);
        reset = 1'b0;
        next_cycle();
        chk("midrst_fill", busy, 0);

        r_m0 = '{34'd5, 34'd9, 34'd2,  34'd1, 34'd0, 34'd3, 34'd4, 34'd6};
        r_m1 = '{34'd1, 34'd9, 34'd30, 34'd2, 34'd8, 34'd7, 34'd0, 34'd5};
        fill_fast();
        feed_drain(4'd5, 34'd30, 4'd0, 34'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
